spi_frame_pingpong: RTL and testbench
=====================================

Name: spi_frame_pingpong

Overview:
Parametrised double-buffered frame assembler between the SPI byte receiver and the FFT engine. It synchronises the SPI done strobe and converts each offset-binary byte to a signed sample. Samples are written into one of two FFT_SIZE-deep banks. A full bank is handed to the FFT through a ready/ack handshake, so capture of the next frame overlaps processing of the current one.

Parameters:
DIN_WIDTH, 8, width of SPI sample byte (offset binary)
BIT_WIDTH, 16, width of signed sample presented to FFT (>= DIN_WIDTH)
N, 9, log2 of frame length
FFT_SIZE, 512, samples per frame (must equal 2**N)
SILENCE_THRESH, 4, peak magnitude (DIN_WIDTH units) below which a frame is silent (optional feature only)

Ports:
clk_in  input  1  system clock
reset  input  1  asynchronous, active-low reset
spi_tran_done  input  1  strobe from SPI receiver, asynchronous to clk_in, high >= 2 clk_in periods
din_spi  input  DIN_WIDTH  sample byte, stable while spi_tran_done high
rd_addr  input  N  FFT read address into presented bank
rd_data  output  BIT_WIDTH  signed sample, registered
frame_ready  output  1  presented bank holds a complete frame
frame_ack  input  1  single-cycle release of presented bank
frame_count  output  8  wrapping count of completed frames
overflow  output  1  sticky; a sample was dropped
frame_silent  output  1  presented frame below SILENCE_THRESH (optional)

Behaviour:
- Reset (async assert, sync release): all outputs 0; both banks FREE; wr_bank = rd_bank = 0; wr_ptr = 0; FSM = FILL. A partial frame in progress at reset is discarded.
- spi_tran_done passes through a 2-flop synchroniser. Capture happens on the rising edge of the synchronised level, one capture per strobe. Capture occurs 3 clk_in edges after spi_tran_done rises.
- Conversion: sample = {~din[DIN_WIDTH-1], din[DIN_WIDTH-2:0]} placed in the MSBs, LSBs zero. Examples: 0x80->0x0000, 0xFF->0x7F00, 0x00->0x8000.
- FILL: each capture writes mem[wr_bank][wr_ptr] and increments wr_ptr. On the write at wr_ptr = FFT_SIZE-1:
  - wr_ptr wraps to 0, bank[wr_bank] becomes FULL, frame_count increments.
  - If bank[~wr_bank] is FREE, or is freed by an ack in the same cycle, wr_bank toggles and the FSM stays in FILL.
  - Otherwise the FSM goes to STALL.
- STALL: captures are dropped and each one sets overflow. On ack, wr_bank becomes the freed bank and the FSM returns to FILL. No sample is written in the ack cycle.
- frame_ready is registered = (bank[rd_bank] == FULL). It rises the cycle after the final-sample write.
- Ack handling:
  - frame_ack with frame_ready high sets bank[rd_bank] to FREE and toggles rd_bank. frame_ready goes low the next cycle.
  - If the other bank is already FULL, frame_ready reasserts one cycle later, giving exactly one low cycle.
  - frame_ack while frame_ready is low is ignored.
- rd_data = mem[rd_bank][rd_addr], 1-cycle latency. It is valid only while frame_ready is high; otherwise undefined.
- overflow clears only on reset. frame_count wraps 255->0.

Optional Feature:
SILENCE_DETECT_EN
- Defined: during FILL, track the peak |din - 2**(DIN_WIDTH-1)| per bank. At frame completion, latch that bank's flag = (peak < SILENCE_THRESH) and reset the peak. frame_silent is the rd_bank flag ANDed with frame_ready.
- Undefined: frame_silent tied 0; no peak logic synthesised.

Test Plan:
1. Reset low 10 us, then send 512 bytes ramp 0x00..0xFF twice -> frame_ready high 1 cycle after 512th capture. frame_count=1. rd_addr=0 gives 0x8000; rd_addr=255 gives 0x7F00; rd_addr=511 gives 0x7F00.
2. Send 1024 bytes (frame A all 0x90, frame B all 0x70) with no ack until both complete -> overflow=0. Ack A: frame_ready low exactly 1 cycle, then high. Read gives 0xF000. frame_count=2.
3. Hold ack and send 3 full frames -> 512 bytes of frame 3 dropped, overflow=1, frame_count=2. After ack, next 512 bytes fill the freed bank and frame_count=3.
4. Pulse ack in the same cycle as the final sample of frame 2 while frame 1 is presented -> no STALL, overflow=0, frame 2 presented after a 1-cycle gap.
5. Assert reset after 300 bytes -> all outputs 0. The next 512 bytes form a clean frame with frame_count=1.
6. With SILENCE_DETECT_EN defined: a frame of all 0x80 gives frame_silent=1; a frame containing one 0x84 byte gives frame_silent=0. Without the macro, frame_silent stays 0 for both.

Source files
------------

// File: rtl/spi_frame_pingpong.sv
// Double-buffered frame assembler between the SPI byte receiver and the FFT engine.
// Bytes arrive on an asynchronous done strobe. Each byte is converted from offset binary
// to a signed sample and written into one of two frame banks. A full bank is presented
// to the FFT through a ready/ack handshake while the other bank fills.
// Optional feature macro: SILENCE_DETECT_EN (per-frame silence flag on frame_silent).
module spi_frame_pingpong #(
    parameter int unsigned DIN_WIDTH      = 8,
    parameter int unsigned BIT_WIDTH      = 16,
    parameter int unsigned N              = 9,
    parameter int unsigned FFT_SIZE       = 512,
    parameter int unsigned SILENCE_THRESH = 4
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 spi_tran_done,
    input  logic [DIN_WIDTH-1:0] din_spi,
    input  logic [N-1:0]         rd_addr,
    output logic [BIT_WIDTH-1:0] rd_data,
    output logic                 frame_ready,
    input  logic                 frame_ack,
    output logic [7:0]           frame_count,
    output logic                 overflow,
    output logic                 frame_silent
);

    typedef enum logic [0:0] {StFill, StStall} state_e;

    state_e         state_q, state_d;
    logic           sync1_q, sync2_q, sync3_q;
    logic           capture;
    logic [N-1:0]   wr_ptr_q, wr_ptr_d;
    logic           wr_bank_q, wr_bank_d;
    logic           rd_bank_q, rd_bank_d;
    logic [1:0]     bank_full_q, bank_full_d;
    logic           frame_ready_q, frame_ready_d;
    logic [7:0]     frame_count_q, frame_count_d;
    logic           overflow_q, overflow_d;
    logic           ack_ok;
    logic           wr_en;
    logic           frame_done;
    logic [BIT_WIDTH-1:0] sample;

    logic [BIT_WIDTH-1:0] mem [2*FFT_SIZE];

    // Two-flop synchroniser plus a delay flop for rising-edge detection of the strobe.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= spi_tran_done;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign capture = sync2_q & ~sync3_q;
    assign ack_ok  = frame_ack & frame_ready_q;

    // Flip the offset-binary MSB to get two's complement, then left-justify.
    assign sample = BIT_WIDTH'({~din_spi[DIN_WIDTH-1], din_spi[DIN_WIDTH-2:0]})
                    << (BIT_WIDTH - DIN_WIDTH);

    // Next-state logic for the fill/stall FSM, bank ownership and status counters.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        bank_full_d   = bank_full_q;
        frame_count_d = frame_count_q;
        overflow_d    = overflow_q;
        wr_en         = 1'b0;
        frame_done    = 1'b0;

        if (ack_ok) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
        end

        unique case (state_q)
            StFill: begin
                if (capture) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == N'(FFT_SIZE - 1)) begin
                        frame_done             = 1'b1;
                        wr_ptr_d               = '0;
                        bank_full_d[wr_bank_q] = 1'b1;
                        frame_count_d          = frame_count_q + 8'd1;
                        // An ack this cycle frees the other bank in time to keep filling.
                        if (!bank_full_q[~wr_bank_q] || (ack_ok && (rd_bank_q != wr_bank_q))) begin
                            wr_bank_d = ~wr_bank_q;
                        end else begin
                            state_d = StStall;
                        end
                    end
                end
            end
            StStall: begin
                if (capture) begin
                    overflow_d = 1'b1;
                end
                if (ack_ok) begin
                    wr_bank_d = rd_bank_q;
                    state_d   = StFill;
                end
            end
            default: state_d = StFill;
        endcase

        // Forced low on ack so the handoff always shows at least one idle cycle.
        frame_ready_d = ack_ok ? 1'b0 : bank_full_q[rd_bank_q];
    end

    // Control and status registers.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q       <= StFill;
            wr_ptr_q      <= '0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            bank_full_q   <= '0;
            frame_ready_q <= 1'b0;
            frame_count_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            bank_full_q   <= bank_full_d;
            frame_ready_q <= frame_ready_d;
            frame_count_q <= frame_count_d;
            overflow_q    <= overflow_d;
        end
    end

    // Sample storage; bank select is the top address bit.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[{wr_bank_q, wr_ptr_q}] <= sample;
        end
    end

    // Registered read port into the presented bank.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[{rd_bank_q, rd_addr}];
        end
    end

    assign frame_ready = frame_ready_q;
    assign frame_count = frame_count_q;
    assign overflow    = overflow_q;

`ifdef SILENCE_DETECT_EN
    localparam logic [DIN_WIDTH-1:0] Half   = DIN_WIDTH'(1) << (DIN_WIDTH - 1);
    localparam logic [DIN_WIDTH:0]   Thresh = (DIN_WIDTH + 1)'(SILENCE_THRESH);

    logic [DIN_WIDTH-1:0] peak_q;
    logic [DIN_WIDTH-1:0] mag;
    logic [DIN_WIDTH-1:0] peak_max;
    logic [1:0]           silent_q;

    // Distance of the incoming byte from mid-scale and the running peak including it.
    always_comb begin
        mag      = din_spi[DIN_WIDTH-1] ? (din_spi - Half) : (Half - din_spi);
        peak_max = (mag > peak_q) ? mag : peak_q;
    end

    // Peak tracker for the filling bank; the flag is latched when that bank completes.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            peak_q   <= '0;
            silent_q <= '0;
        end else if (wr_en) begin
            if (frame_done) begin
                silent_q[wr_bank_q] <= ({1'b0, peak_max} < Thresh);
                peak_q              <= '0;
            end else begin
                peak_q <= peak_max;
            end
        end
    end

    assign frame_silent = silent_q[rd_bank_q] & frame_ready_q;
`else
    logic unused_silence_thresh;
    assign unused_silence_thresh = ^SILENCE_THRESH;
    assign frame_silent          = 1'b0;
`endif

endmodule

// File: tb/tb_spi_frame_pingpong.sv
// Self-checking bench for spi_frame_pingpong: random bytes and gaps, checked against a
// frame-level queue model of the double buffer.
module tb_spi_frame_pingpong;

    logic        clk_in = 1'b0;
    logic        reset = 1'b0;
    logic        spi_tran_done = 1'b0;
    logic [7:0]  din_spi = 8'h00;
    logic [8:0]  rd_addr = 9'd0;
    logic [15:0] rd_data;
    logic        frame_ready;
    logic        frame_ack = 1'b0;
    logic [7:0]  frame_count;
    logic        overflow;
    logic        frame_silent;

    int errors = 0;
    int checks = 0;

    // Model state: completed frames in presentation order, partial frame, status.
    int m_full[$];
    bit m_silent[$];
    int m_part[$];
    int m_peak;
    bit m_stall;
    int m_count;
    bit m_ovf;

    spi_frame_pingpong dut (
        .clk_in        (clk_in),
        .reset         (reset),
        .spi_tran_done (spi_tran_done),
        .din_spi       (din_spi),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .frame_ready   (frame_ready),
        .frame_ack     (frame_ack),
        .frame_count   (frame_count),
        .overflow      (overflow),
        .frame_silent  (frame_silent)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        repeat (200000) @(posedge clk_in);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_full.delete();
        m_silent.delete();
        m_part.delete();
        m_peak  = 0;
        m_stall = 1'b0;
        m_count = 0;
        m_ovf   = 1'b0;
    endfunction

    function automatic void model_ack();
        if (m_full.size() >= 512) begin
            repeat (512) void'(m_full.pop_front());
            void'(m_silent.pop_front());
            m_stall = 1'b0;
        end
    endfunction

    function automatic void model_byte(input int b);
        int mag;
        if (m_stall) begin
            m_ovf = 1'b1;
        end else begin
            m_part.push_back(((b + 128) % 256) * 256);
            mag = (b >= 128) ? (b - 128) : (128 - b);
            if (mag > m_peak) m_peak = mag;
            if (m_part.size() == 512) begin
                foreach (m_part[i]) m_full.push_back(m_part[i]);
                m_part.delete();
                m_silent.push_back(m_peak < 4);
                m_peak  = 0;
                m_count = (m_count + 1) % 256;
                if (m_full.size() == 1024) m_stall = 1'b1;
            end
        end
    endfunction

    function automatic bit exp_ready();
        return m_full.size() >= 512;
    endfunction

    function automatic bit exp_silent();
`ifdef SILENCE_DETECT_EN
        return exp_ready() ? m_silent[0] : 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic do_reset(input int cycles);
        @(negedge clk_in);
        reset = 1'b0;
        frame_ack = 1'b0;
        spi_tran_done = 1'b0;
        rd_addr = 9'd0;
        repeat (cycles) @(negedge clk_in);
        check_eq("rst_rd_data", 32'(rd_data), 0);
        check_eq("rst_frame_ready", 32'(frame_ready), 0);
        check_eq("rst_frame_count", 32'(frame_count), 0);
        check_eq("rst_overflow", 32'(overflow), 0);
        check_eq("rst_frame_silent", 32'(frame_silent), 0);
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk_in);
    endtask

    // Strobe rises on a falling clock edge; capture lands on the third rising edge after.
    task automatic send_byte(input int b, input bit ack_at_cap);
        repeat ($urandom_range(2, 4)) @(negedge clk_in);
        din_spi = 8'(b);
        spi_tran_done = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        if (ack_at_cap) begin
            check_eq("ack_at_cap_ready", 32'(frame_ready), 1);
            frame_ack = 1'b1;
        end
        @(negedge clk_in);
        frame_ack = 1'b0;
        spi_tran_done = 1'b0;
        if (ack_at_cap) model_ack();
        model_byte(b);
    endtask

    task automatic send_random(input int count);
        for (int i = 0; i < count; i++) send_byte(int'($urandom_range(0, 255)), 1'b0);
    endtask

    task automatic check_state(input string tag);
        repeat (2) @(negedge clk_in);
        check_eq({tag, "_ready"}, 32'(frame_ready), 32'(exp_ready()));
        check_eq({tag, "_count"}, 32'(frame_count), 32'(m_count));
        check_eq({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
        check_eq({tag, "_silent"}, 32'(frame_silent), 32'(exp_silent()));
    endtask

    task automatic check_frame(input string tag);
        @(negedge clk_in);
        rd_addr = 9'd0;
        for (int a = 0; a < 512; a++) begin
            @(negedge clk_in);
            check_eq(tag, 32'(rd_data), 32'(m_full[a]));
            if (a < 511) rd_addr = 9'(a + 1);
        end
    endtask

    task automatic read_at(input string tag, input int addr, input int exp);
        @(negedge clk_in);
        rd_addr = 9'(addr);
        @(negedge clk_in);
        check_eq(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic do_ack(input string tag);
        @(negedge clk_in);
        check_eq({tag, "_pre"}, 32'(frame_ready), 1);
        frame_ack = 1'b1;
        @(negedge clk_in);
        frame_ack = 1'b0;
        model_ack();
        check_eq({tag, "_low"}, 32'(frame_ready), 0);
        @(negedge clk_in);
        check_eq({tag, "_after"}, 32'(frame_ready), 32'(exp_ready()));
    endtask

    initial begin
        int pos;
        model_reset();

        // Ramp frame: timing of frame_ready and fixed conversion points.
        do_reset(1000);
        for (int i = 0; i < 512; i++) send_byte(i % 256, 1'b0);
        check_eq("t1_ready_lag", 32'(frame_ready), 0);
        @(negedge clk_in);
        check_eq("t1_ready_rise", 32'(frame_ready), 1);
        check_state("t1");
        read_at("t1_addr0", 0, 16'h8000);
        read_at("t1_addr255", 255, 16'h7F00);
        read_at("t1_addr511", 511, 16'h7F00);
        check_frame("t1_data");

        // Two constant frames, no ack until both are full.
        do_reset(5);
        for (int i = 0; i < 512; i++) send_byte(8'h90, 1'b0);
        for (int i = 0; i < 512; i++) send_byte(8'h70, 1'b0);
        check_state("t2_full");
        read_at("t2_frame_a", 17, 16'h1000);
        do_ack("t2_ack");
        read_at("t2_frame_b", 300, 16'hF000);
        check_state("t2_post");
        check_frame("t2_data");

        // Third frame arrives with both banks held: dropped, then recovery after ack.
        do_reset(5);
        send_random(1536);
        check_state("t3_stall");
        do_ack("t3_ack1");
        send_random(512);
        check_state("t3_refill");
        check_frame("t3_frame2");
        do_ack("t3_ack2");
        check_frame("t3_frame4");

        // Ack coincides with the last sample of frame 2.
        do_reset(5);
        send_random(512);
        check_state("t4_f1");
        send_random(511);
        send_byte(int'($urandom_range(0, 255)), 1'b1);
        check_eq("t4_gap", 32'(frame_ready), 0);
        @(negedge clk_in);
        check_eq("t4_reassert", 32'(frame_ready), 1);
        check_state("t4_f2");
        check_frame("t4_data");

        // Reset in the middle of a frame discards the partial frame.
        do_reset(5);
        send_random(300);
        do_reset(5);
        send_random(512);
        check_state("t5");
        check_frame("t5_data");

        // Silence: mid-scale frame, then a frame with one byte at threshold distance.
        do_reset(5);
        for (int i = 0; i < 512; i++) send_byte(8'h80, 1'b0);
        check_state("t6_quiet");
        pos = int'($urandom_range(0, 511));
        for (int i = 0; i < 512; i++) send_byte((i == pos) ? 8'h84 : 8'h80, 1'b0);
        check_state("t6_both");
        do_ack("t6_ack");
        check_state("t6_loud");
        read_at("t6_peak", pos, 16'h0400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
